// File: rtl/ddr4_phy_pkg.sv
// Shared definitions for the DDR4 command/address PHY lane logic:
// the tap-control FSM state encoding and the serializer word width.
package ddr4_phy_pkg;

    // Width of one 4:1 serializer word per IOD lane.
    localparam int SER_W = 4;

    // Tap-control FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIR,
        ST_STEP,
        ST_SETTLE,
        ST_FIN,
        ST_ABORT
    } ca_state_e;

endpackage

// File: rtl/ddr4_ca_pipe.sv
// Fixed-latency register chain for the TX/OE serializer words.
// Output equals input delayed by exactly DEPTH clock cycles.
module ddr4_ca_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift the word one stage per cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: this array is a short flop chain, not a RAM, so every
            // stage is reset to keep the IODs quiet until real data arrives.
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value, giving a true shift register.
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/ddr4_ca_lane_delay_ctrl.sv
// DDR4 command/address lane delay controller. Walks one IOD delay line at
// a time to a requested tap with single MOVE pulses separated by a settle
// window, tracks the tap per lane, and flags range errors from the IOD.
// TX/OE serializer words pass through a fixed-latency pipeline untouched.
module ddr4_ca_lane_delay_ctrl
    import ddr4_phy_pkg::*;
#(
    parameter int NUM_LANES  = 8,
    parameter int TAP_W      = 8,
    parameter int SETTLE_CYC = 4,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                                             i_fab_clk,
    input  logic                                             i_arst_n,
    input  logic                                             i_req_valid,
    output logic                                             o_req_ready,
    input  logic [$clog2(NUM_LANES > 1 ? NUM_LANES : 2)-1:0] i_req_lane,
    input  logic [TAP_W-1:0]                                 i_req_tap,
    input  logic                                             i_req_load,
    output logic                                             o_done,
    output logic                                             o_err_oor,
    output logic [$clog2(NUM_LANES > 1 ? NUM_LANES : 2)-1:0] o_err_lane,
    input  logic                                             i_err_clr,
    output logic [NUM_LANES*TAP_W-1:0]                       o_cur_tap,
    output logic [NUM_LANES-1:0]                             o_delay_line_move,
    output logic [NUM_LANES-1:0]                             o_delay_line_direction,
    output logic [NUM_LANES-1:0]                             o_delay_line_load,
    input  logic [NUM_LANES-1:0]                             i_delay_line_out_of_range,
    input  logic [NUM_LANES*SER_W-1:0]                       i_tx_data_in,
    input  logic [NUM_LANES*SER_W-1:0]                       i_oe_data_in,
    output logic [NUM_LANES*SER_W-1:0]                       o_tx_data_out,
    output logic [NUM_LANES*SER_W-1:0]                       o_oe_data_out
);

    localparam int LANE_W = $clog2(NUM_LANES > 1 ? NUM_LANES : 2);
    localparam int WORD_W = NUM_LANES * SER_W;

    ca_state_e            r_state;
    logic                 r_req_ready;
    logic                 r_done;
    logic                 r_err_oor;
    logic [LANE_W-1:0]    r_err_lane;
    logic [LANE_W-1:0]    r_lane;
    logic [TAP_W-1:0]     r_target;
    logic [7:0]           r_settle_cnt;
    logic [TAP_W-1:0]     r_cur_tap [NUM_LANES];
    logic [NUM_LANES-1:0] r_move;
    logic [NUM_LANES-1:0] r_dir;
    logic [NUM_LANES-1:0] r_load;

    logic [NUM_LANES-1:0] w_lane_sel;
    logic [NUM_LANES-1:0] w_req_sel;
    logic [TAP_W-1:0]     w_cur;
    logic                 w_step_up;
    logic                 w_blocked;

    assign w_lane_sel = NUM_LANES'(1) << r_lane;
    assign w_req_sel  = NUM_LANES'(1) << i_req_lane;
    assign w_cur      = r_cur_tap[r_lane];
    assign w_step_up  = (r_target > w_cur);
    // A step that would wrap the tracked tap is refused and ends as an abort.
    assign w_blocked  = w_step_up ? (&w_cur) : (w_cur == '0);

    // Tap-control FSM with registered handshake, strobe and error outputs.
    always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b0;
            r_done       <= 1'b0;
            r_err_oor    <= 1'b0;
            r_err_lane   <= '0;
            r_lane       <= '0;
            r_target     <= '0;
            r_settle_cnt <= '0;
            r_move       <= '0;
            r_dir        <= '0;
            r_load       <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_cur_tap[i] <= '0;
            end
        end else begin
            r_move <= '0;
            r_load <= '0;
            r_done <= 1'b0;
            // A clear is overridden by an abort in the same cycle (later write wins).
            if (i_err_clr) begin
                r_err_oor  <= 1'b0;
                r_err_lane <= '0;
            end
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (i_req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_lane      <= i_req_lane;
                        r_target    <= i_req_tap;
                        if (i_req_load) begin
                            r_load                <= w_req_sel;
                            r_cur_tap[i_req_lane] <= '0;
                            r_state               <= ST_LOAD;
                        end else begin
                            r_state <= ST_DIR;
                        end
                    end
                end
                ST_LOAD: begin
                    r_settle_cnt <= 8'(SETTLE_CYC - 1);
                    r_state      <= ST_SETTLE;
                end
                ST_DIR: begin
                    if (w_cur == r_target) begin
                        r_state <= ST_FIN;
                    end else if (w_blocked) begin
                        r_state <= ST_ABORT;
                    end else begin
                        r_dir[r_lane]     <= w_step_up;
                        r_move            <= w_lane_sel;
                        r_cur_tap[r_lane] <= w_step_up ? w_cur + TAP_W'(1) : w_cur - TAP_W'(1);
                        r_state           <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    r_settle_cnt <= 8'(SETTLE_CYC - 1);
                    r_state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_state <= i_delay_line_out_of_range[r_lane] ? ST_ABORT : ST_DIR;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 8'd1;
                    end
                end
                ST_FIN: begin
                    r_done      <= 1'b1;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                ST_ABORT: begin
                    r_err_oor   <= 1'b1;
                    r_err_lane  <= r_lane;
                    r_done      <= 1'b1;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Flatten the per-lane tap array, lane 0 in the LSBs.
    always_comb begin
        // NOTE: default first so no path leaves the output unassigned,
        // which would otherwise infer a latch.
        o_cur_tap = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            o_cur_tap[i*TAP_W +: TAP_W] = r_cur_tap[i];
        end
    end

    assign o_req_ready            = r_req_ready;
    assign o_done                 = r_done;
    assign o_err_oor              = r_err_oor;
    assign o_err_lane             = r_err_lane;
    assign o_delay_line_move      = r_move;
    assign o_delay_line_direction = r_dir;
    assign o_delay_line_load      = r_load;

    logic [2*WORD_W-1:0] w_pipe_out;

    ddr4_ca_pipe #(
        .WIDTH (2 * WORD_W),
        .DEPTH (PIPE_DEPTH)
    ) u_pipe (
        .i_clk   (i_fab_clk),
        .i_rst_n (i_arst_n),
        .i_data  ({i_oe_data_in, i_tx_data_in}),
        .o_data  (w_pipe_out)
    );

    assign o_tx_data_out = w_pipe_out[WORD_W-1:0];
    assign o_oe_data_out = w_pipe_out[2*WORD_W-1:WORD_W];

endmodule

// File: tb/tb_ddr4_ca_lane_delay_ctrl.sv
// Directed bench for ddr4_ca_lane_delay_ctrl: 8 lanes, 8-bit taps,
// SETTLE_CYC=4, PIPE_DEPTH=3. Expected cycle counts are written out by hand.
module tb_ddr4_ca_lane_delay_ctrl;

    localparam int NL   = 8;
    localparam int TW   = 8;
    localparam int SC   = 4;
    localparam int PD   = 3;

    logic           i_fab_clk = 1'b0;
    logic           i_arst_n;
    logic           i_req_valid;
    logic           o_req_ready;
    logic [2:0]     i_req_lane;
    logic [TW-1:0]  i_req_tap;
    logic           i_req_load;
    logic           o_done;
    logic           o_err_oor;
    logic [2:0]     o_err_lane;
    logic           i_err_clr;
    logic [63:0]    o_cur_tap;
    logic [NL-1:0]  o_move;
    logic [NL-1:0]  o_dir;
    logic [NL-1:0]  o_load;
    logic [NL-1:0]  i_oor;
    logic [31:0]    i_tx_data_in;
    logic [31:0]    i_oe_data_in;
    logic [31:0]    o_tx_data_out;
    logic [31:0]    o_oe_data_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [TW-1:0] exp_tap [NL];

    ddr4_ca_lane_delay_ctrl #(
        .NUM_LANES  (NL),
        .TAP_W      (TW),
        .SETTLE_CYC (SC),
        .PIPE_DEPTH (PD)
    ) dut (
        .i_fab_clk                 (i_fab_clk),
        .i_arst_n                  (i_arst_n),
        .i_req_valid               (i_req_valid),
        .o_req_ready               (o_req_ready),
        .i_req_lane                (i_req_lane),
        .i_req_tap                 (i_req_tap),
        .i_req_load                (i_req_load),
        .o_done                    (o_done),
        .o_err_oor                 (o_err_oor),
        .o_err_lane                (o_err_lane),
        .i_err_clr                 (i_err_clr),
        .o_cur_tap                 (o_cur_tap),
        .o_delay_line_move         (o_move),
        .o_delay_line_direction    (o_dir),
        .o_delay_line_load         (o_load),
        .i_delay_line_out_of_range (i_oor),
        .i_tx_data_in              (i_tx_data_in),
        .i_oe_data_in              (i_oe_data_in),
        .o_tx_data_out             (o_tx_data_out),
        .o_oe_data_out             (o_oe_data_out)
    );

    always #5 i_fab_clk = ~i_fab_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_flat();
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < NL; i++) f[i*TW +: TW] = exp_tap[i];
        return f;
    endfunction

    // Serializer stream: lane 1 alternates A/5, other nibbles random.
    // The history model expects each word back exactly PD cycles later.
    logic [31:0] tx_hist [PD];
    logic [31:0] oe_hist [PD];
    int  pipe_bad = 0;
    bit  tog = 1'b0;
    always @(negedge i_fab_clk) begin
        logic [31:0] tw;
        logic [31:0] ow;
        tw = $urandom;
        tw[7:4] = tog ? 4'hA : 4'h5;
        tog = !tog;
        ow = $urandom;
        if (!i_arst_n) begin
            for (int i = 0; i < PD; i++) begin
                tx_hist[i] = '0;
                oe_hist[i] = '0;
            end
        end else begin
            if (o_tx_data_out !== tx_hist[PD-1] || o_oe_data_out !== oe_hist[PD-1]) pipe_bad++;
            for (int i = PD-1; i > 0; i--) begin
                tx_hist[i] = tx_hist[i-1];
                oe_hist[i] = oe_hist[i-1];
            end
            tx_hist[0] = tw;
            oe_hist[0] = ow;
        end
        i_tx_data_in = tw;
        i_oe_data_in = ow;
    end

    // Issue one request and observe it cycle by cycle. Cycle c counts
    // falling edges after valid was driven (handshake edge lies before c=1).
    task automatic run_req(input string tag, input int lane, input int tap, input bit load,
                           input int exp_moves, input bit exp_dir, input int exp_done,
                           input int oor_after, input bit hold_clr, input int busy_at,
                           input int exp_final);
        int  moves = 0, loads = 0, dones = 0, done_cyc = -1;
        int  first_move = -1, last_move = -1, gap_bad = 0, dir_bad = 0, stray = 0;
        int  wait_cyc = 0;
        bit  err_at_done = 1'b0;
        logic [NL-1:0] sel;
        sel = NL'(1) << lane;
        while (!o_req_ready && wait_cyc < 50) begin
            @(negedge i_fab_clk);
            wait_cyc++;
        end
        check({tag, "_ready"}, o_req_ready, 1);
        if (oor_after == 0) i_oor[lane] = 1'b1;
        i_err_clr   = hold_clr;
        i_req_valid = 1'b1;
        i_req_lane  = 3'(lane);
        i_req_tap   = TW'(tap);
        i_req_load  = load;
        for (int c = 1; c <= 300; c++) begin
            @(negedge i_fab_clk);
            if (c == 1) i_req_valid = 1'b0;
            if (busy_at > 0 && c == busy_at) begin
                i_req_valid = 1'b1;
                i_req_lane  = 3'd6;
                i_req_tap   = 8'd3;
                i_req_load  = 1'b0;
            end
            if (busy_at > 0 && c == busy_at + 1) i_req_valid = 1'b0;
            stray += $countones(o_move & ~sel) + $countones(o_load & ~sel);
            if (o_move[lane]) begin
                moves++;
                if (o_dir[lane] !== exp_dir) dir_bad++;
                if (last_move >= 0 && c - last_move != SC + 2) gap_bad++;
                if (first_move < 0) first_move = c;
                last_move = c;
                if (moves == oor_after) i_oor[lane] = 1'b1;
            end
            if (o_load[lane]) loads++;
            if (o_done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc    = c;
                    err_at_done = o_err_oor;
                    i_oor       = '0;
                    if (hold_clr) i_err_clr = 1'b0;
                end
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        i_oor     = '0;
        i_err_clr = 1'b0;
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_done_count"}, dones, 1);
        check({tag, "_moves"}, moves, exp_moves);
        check({tag, "_loads"}, loads, load);
        check({tag, "_first_move"}, first_move, exp_moves == 0 ? -1 : (load ? 7 : 2));
        check({tag, "_move_spacing"}, gap_bad, 0);
        check({tag, "_direction"}, dir_bad, 0);
        check({tag, "_stray_strobes"}, stray, 0);
        check({tag, "_err_at_done"}, err_at_done, oor_after >= 0);
        exp_tap[lane] = TW'(exp_final);
        check({tag, "_cur_tap"}, o_cur_tap, exp_flat());
    endtask

    initial begin
        i_arst_n    = 1'b0;
        i_req_valid = 1'b0;
        i_req_lane  = '0;
        i_req_tap   = '0;
        i_req_load  = 1'b0;
        i_err_clr   = 1'b0;
        i_oor       = '0;
        for (int i = 0; i < NL; i++) exp_tap[i] = '0;

        // Reset values
        repeat (3) @(negedge i_fab_clk);
        check("rst_ready", o_req_ready, 0);
        check("rst_done", o_done, 0);
        check("rst_err", {o_err_oor, o_err_lane}, 0);
        check("rst_strobes", {o_move, o_dir, o_load}, 0);
        check("rst_cur_tap", o_cur_tap, 0);
        check("rst_tx_oe", {o_tx_data_out, o_oe_data_out}, 0);
        @(posedge i_fab_clk);
        #2 i_arst_n = 1'b1;
        repeat (2) @(negedge i_fab_clk);
        check("ready_after_rst", o_req_ready, 1);

        // Lane 3 up to 5; a stray request mid-flight must be ignored
        run_req("l3_up5", 3, 5, 1'b0, 5, 1'b1, 33, -1, 1'b0, 4, 5);
        // Lane 3 down to 2
        run_req("l3_dn2", 3, 2, 1'b0, 3, 1'b0, 21, -1, 1'b0, 0, 2);
        // Lane 0 to 7, then reload and climb to 4
        run_req("l0_up7", 0, 7, 1'b0, 7, 1'b1, 45, -1, 1'b0, 0, 7);
        run_req("l0_load4", 0, 4, 1'b1, 4, 1'b1, 32, -1, 1'b0, 0, 4);
        // Target equals current: no MOVE, DONE three cycles after handshake
        run_req("l0_same", 0, 4, 1'b0, 0, 1'b1, 3, -1, 1'b0, 0, 4);

        // Range error after the second step toward 9
        run_req("l2_abort", 2, 9, 1'b0, 2, 1'b1, 14, 2, 1'b0, 0, 2);
        check("abort_err_oor", o_err_oor, 1);
        check("abort_err_lane", o_err_lane, 2);
        @(negedge i_fab_clk);
        i_err_clr = 1'b1;
        @(negedge i_fab_clk);
        i_err_clr = 1'b0;
        check("clr_err", {o_err_oor, o_err_lane}, 0);

        // Clear held across a new abort: the set must win
        run_req("l2_setwins", 2, 9, 1'b0, 1, 1'b1, 8, 0, 1'b1, 0, 3);
        check("setwins_err_oor", o_err_oor, 1);
        check("setwins_err_lane", o_err_lane, 2);

        // Reset during SETTLE: everything drops at once, no DONE follows
        begin
            int late = 0;
            int w = 0;
            while (!o_req_ready && w < 50) begin
                @(negedge i_fab_clk);
                w++;
            end
            i_req_valid = 1'b1;
            i_req_lane  = 3'd5;
            i_req_tap   = 8'd10;
            i_req_load  = 1'b0;
            @(negedge i_fab_clk);
            i_req_valid = 1'b0;
            repeat (3) @(negedge i_fab_clk);
            check("midop_cur_tap_l5", o_cur_tap[5*TW +: TW], 1);
            #1 i_arst_n = 1'b0;
            #1;
            check("midop_strobes", {o_move, o_dir, o_load}, 0);
            check("midop_done_ready", {o_done, o_req_ready}, 0);
            check("midop_err", {o_err_oor, o_err_lane}, 0);
            check("midop_cur_tap", o_cur_tap, 0);
            check("midop_tx_oe", {o_tx_data_out, o_oe_data_out}, 0);
            for (int c = 0; c < 4; c++) begin
                @(negedge i_fab_clk);
                if (o_done || (|o_move)) late++;
            end
            @(posedge i_fab_clk);
            #2 i_arst_n = 1'b1;
            for (int c = 0; c < 12; c++) begin
                @(negedge i_fab_clk);
                if (o_done || (|o_move)) late++;
            end
            check("midop_no_late_activity", late, 0);
            for (int i = 0; i < NL; i++) exp_tap[i] = '0;
        end
        run_req("post_rst", 5, 1, 1'b0, 1, 1'b1, 9, -1, 1'b0, 0, 1);

        check("pipe_mismatches", pipe_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr4_ca_lane_delay_ctrl.md
DDR4_CA_LANE_DELAY_CTRL -- requirements
Module: ddr4_ca_lane_delay_ctrl

Interface
REQ-001 Parameter NUM_LANES, default 8: number of command/address IOD lanes served, range 1..32.
REQ-002 Parameter TAP_W, default 8: delay-line tap counter width; max tap is 2^TAP_W-1.
REQ-003 Parameter SETTLE_CYC, default 4: idle cycles after each MOVE pulse before the next action, range 1..255.
REQ-004 Parameter PIPE_DEPTH, default 2: TX/OE register stages, range 1..4.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 FAB_CLK  in  1  fabric clock; all logic is rising-edge.
REQ-007 ARST_N  in  1  asynchronous active-low reset.
REQ-008 REQ_VALID  in  1  tap request valid.
REQ-009 REQ_READY  out  1  high only in IDLE.
REQ-010 REQ_LANE  in  clog2(NUM_LANES)  target lane.
REQ-011 REQ_TAP  in  TAP_W  target tap value.
REQ-012 REQ_LOAD  in  1  1 = reload lane to tap 0 before stepping.
REQ-013 DONE  out  1  one-cycle pulse at request completion.
REQ-014 ERR_OOR  out  1  sticky out-of-range flag; ERR_LANE  out  clog2(NUM_LANES)  lane that raised it; ERR_CLR  in  1  clears both.
REQ-015 CUR_TAP  out  NUM_LANES*TAP_W  tracked tap per lane, lane 0 in LSBs.
REQ-016 DELAY_LINE_MOVE / DELAY_LINE_DIRECTION / DELAY_LINE_LOAD  out  NUM_LANES each  per-lane IOD delay controls.
REQ-017 DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane IOD range flags.
REQ-018 TX_DATA_IN, OE_DATA_IN  in  NUM_LANES*4 each  4:1 serializer words; TX_DATA_OUT, OE_DATA_OUT  out  NUM_LANES*4 each  delayed copies to IODs.

Function
REQ-019 TX_DATA_OUT/OE_DATA_OUT SHALL equal TX_DATA_IN/OE_DATA_IN delayed exactly PIPE_DEPTH cycles, independent of FSM state.
REQ-020 FSM states: IDLE, LOAD, DIR, STEP, SETTLE, FIN, ABORT.
REQ-021 IDLE: on REQ_VALID&REQ_READY, latch lane/tap/load; go LOAD if REQ_LOAD else DIR.
REQ-022 LOAD: assert DELAY_LINE_LOAD[lane] one cycle, set CUR_TAP[lane]=0, then SETTLE.
REQ-023 DIR: if CUR_TAP[lane]==target go FIN; else drive DIRECTION[lane]=1 if target>current (increment) else 0, go STEP; DIRECTION held stable from DIR through SETTLE.
REQ-024 STEP: assert DELAY_LINE_MOVE[lane] exactly one cycle, increment/decrement CUR_TAP[lane] by 1 in that cycle, go SETTLE.
REQ-025 SETTLE: wait SETTLE_CYC cycles; at the last cycle sample OUT_OF_RANGE[lane]: 1 -> ABORT, else DIR.
REQ-026 FIN: pulse DONE one cycle, return IDLE; request with target==current completes with no MOVE pulse, DONE 3 cycles after the handshake.
REQ-027 ABORT: set ERR_OOR=1, ERR_LANE=lane, pulse DONE, return IDLE; CUR_TAP[lane] keeps its last value.
REQ-028 CUR_TAP SHALL never wrap: a step that would pass 0 or 2^TAP_W-1 is suppressed and treated as ABORT.
REQ-029 Only the selected lane's MOVE/LOAD bits SHALL ever be high; all others 0.
REQ-030 ERR_CLR in the same cycle as a new ABORT: set wins.
REQ-031 REQ_VALID while busy is ignored (no queueing).

Reset
REQ-032 ARST_N low SHALL asynchronously force: FSM=IDLE, REQ_READY=0 during reset and 1 the first cycle after release, DONE=0, ERR_OOR=0, ERR_LANE=0, all CUR_TAP=0, all MOVE/DIRECTION/LOAD=0, all pipeline stages and TX_DATA_OUT/OE_DATA_OUT=0.
REQ-033 Reset mid-operation SHALL abort with no further MOVE pulse and no DONE.

Structure
REQ-034 A shared package ddr4_phy_pkg SHALL hold the FSM state enum and the 4-bit serializer-word width constant.
REQ-035 One sub-module ddr4_ca_pipe (PIPE_DEPTH-stage register chain, parameterised width) SHALL implement REQ-019.

Verification
REQ-036 Reset, then REQ lane 3 tap 5 load=0 -> five MOVE[3] pulses, DIRECTION[3]=1, each SETTLE_CYC+2 cycles apart, CUR_TAP[3]=5, one DONE.
REQ-037 From tap 5, REQ lane 3 tap 2 -> three MOVE pulses with DIRECTION=0, CUR_TAP[3]=2.
REQ-038 REQ lane 0 tap 4 load=1 from tap 7 -> one LOAD[0] pulse then four increments, CUR_TAP[0]=4.
REQ-039 OUT_OF_RANGE[2] forced high after second step toward tap 9 -> ABORT, ERR_OOR=1, ERR_LANE=2, CUR_TAP[2]=2, DONE once.
REQ-040 TX_DATA_IN=0xA5 pattern on lane 1 with PIPE_DEPTH=3 -> identical word on TX_DATA_OUT exactly 3 cycles later, unaffected by concurrent stepping.
REQ-041 ARST_N asserted during SETTLE -> all outputs zero immediately, no DONE, next request accepted after release.
